// File: rtl/cu_run_step_controller.sv
// cu_run_step_controller
//   Control stage that sits in front of the control address register (CAR).
//   It synchronizes and debounces the run switch, the step-mode switch and the
//   next-instruction button. It tracks IDLE/RUN/HALT from the halt bit (C23),
//   and it counts instruction fetches by watching the CAR return to 0x00.
//
//   Optional build macro: CU_DEBOUNCE_BYPASS_EN
//     When this macro is defined, the debounce counters are removed. The
//     accepted value is then the synchronized value (2-edge latency), and
//     DEBOUNCE_CYCLES is ignored.
//     When it is undefined, a change is accepted only after it has been
//     stable for DEBOUNCE_CYCLES consecutive cycles.
//
//   Step request handshake:
//     o_next_instr_stimulus is a held request ("valid"). It rises on an
//     accepted button press while in RUN with step mode active. It stays high
//     until the CAR acknowledges by returning to 0x00 from a non-zero
//     address. The request also drops when RUN is left or step mode turns
//     off. Presses that arrive while a request is held are discarded;
//     nothing is queued.
//
//   o_run_state exposes the FSM state directly: 00 IDLE, 01 RUN, 10 HALT.

module cu_run_step_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sw_start,
  input  logic                 i_sw_step,
  input  logic                 i_btn_next,
  input  logic                 i_ctrl_halt,
  input  logic [6:0]           i_car_data,
  output logic                 o_cpu_start,
  output logic                 o_step_execution,
  output logic                 o_next_instr_stimulus,
  output logic [1:0]           o_run_state,
  output logic [CNT_WIDTH-1:0] o_instr_count
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Index of each raw input inside the 3-bit input vectors.
  localparam int IDX_START = 0;
  localparam int IDX_STEP  = 1;
  localparam int IDX_BTN   = 2;

  logic [2:0] raw_in;
  logic [2:0] sync_ff1;
  logic [2:0] sync_ff2;
  logic [2:0] deb;
  logic [2:0] deb_q;

  logic       start_rise;
  logic       start_fall;
  logic       btn_rise;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [6:0] prev_car;
  logic       car_ack;
  logic       step_window;
  logic       step_pending;

  assign raw_in = {i_btn_next, i_sw_step, i_sw_start};

  // Two-flop synchronizer on every raw board input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_ff1 <= 3'b000;
      sync_ff2 <= 3'b000;
    end else begin
      sync_ff1 <= raw_in;
      sync_ff2 <= sync_ff1;
    end
  end

`ifdef CU_DEBOUNCE_BYPASS_EN
  // Debounce bypassed: the synchronized value is accepted as-is.
  assign deb = sync_ff2;
`else
  logic [2:0] deb_r;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic [15:0] db_cnt;

      // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          db_cnt    <= 16'd0;
          deb_r[gi] <= 1'b0;
        end else if (sync_ff2[gi] == deb_r[gi]) begin
          db_cnt <= 16'd0;
        end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
          db_cnt    <= 16'd0;
          deb_r[gi] <= sync_ff2[gi];
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end
    end
  endgenerate

  assign deb = deb_r;
`endif

  // One registered stage on the accepted levels gives single-cycle strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      deb_q <= 3'b000;
    end else begin
      deb_q <= deb;
    end
  end

  assign start_rise = deb[IDX_START] & ~deb_q[IDX_START];
  assign start_fall = ~deb[IDX_START] & deb_q[IDX_START];
  assign btn_rise   = deb[IDX_BTN] & ~deb_q[IDX_BTN];

  // A fetch starts when the CAR returns to 0x00 from a non-zero address.
  assign car_ack = (i_car_data == 7'h00) && (prev_car != 7'h00);

  // Step mode may change only between instructions, or while idle.
  assign step_window = (state == ST_IDLE) || (i_car_data == 7'h00) ||
                       (i_car_data == 7'h20);

  // Next-state logic. A start fall wins over halt; HALT is left only by a start fall.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start_fall) begin
          state_nxt = ST_IDLE;
        end else if (i_ctrl_halt) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (start_fall) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; the CPU-start level is registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_cpu_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_cpu_start <= (state_nxt != ST_IDLE);
    end
  end

  assign o_run_state = state;

  // Step-mode level follows the debounced switch only inside the step window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_step_execution <= 1'b0;
    end else if (step_window) begin
      o_step_execution <= deb[IDX_STEP];
    end
  end

  // Held step request. Ack beats a simultaneous press; presses while pending are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_pending <= 1'b0;
    end else if ((state_nxt != ST_RUN) || !o_step_execution) begin
      step_pending <= 1'b0;
    end else if (car_ack) begin
      step_pending <= 1'b0;
    end else if (btn_rise && (state == ST_RUN)) begin
      step_pending <= 1'b1;
    end
  end

  assign o_next_instr_stimulus = step_pending;

  // Instruction counter: cleared on start, counts fetches in RUN, saturates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_instr_count <= '0;
    end else if ((state == ST_IDLE) && start_rise) begin
      o_instr_count <= '0;
    end else if ((state == ST_RUN) && car_ack && (o_instr_count != CNT_MAX)) begin
      o_instr_count <= o_instr_count + 1'b1;
    end
  end

  // Previous CAR value, used to detect the return to address 0x00.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_car <= 7'h00;
    end else begin
      prev_car <= i_car_data;
    end
  end

endmodule

// File: tb/tb_cu_run_step_controller.sv
// tb_cu_run_step_controller
//   Bench for cu_run_step_controller (DEBOUNCE_CYCLES=4, CNT_WIDTH=4).
//   The reference model keeps a history of raw input samples. A debounced
//   level changes when the last DEBOUNCE_CYCLES synchronized samples all
//   disagree with it. FSM, step and counter rules are applied per edge.
//   Expected outputs are queued at each rising edge and compared on the
//   following falling edge. Directed phases follow the intended use; a
//   randomized phase follows them.

module tb_cu_run_step_controller;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int CNT_TOP = (1 << CW) - 1;

  logic          i_clk;
  logic          i_rst;
  logic          i_sw_start;
  logic          i_sw_step;
  logic          i_btn_next;
  logic          i_ctrl_halt;
  logic [6:0]    i_car_data;
  logic          o_cpu_start;
  logic          o_step_execution;
  logic          o_next_instr_stimulus;
  logic [1:0]    o_run_state;
  logic [CW-1:0] o_instr_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];

  cu_run_step_controller #(
    .DEBOUNCE_CYCLES (16'd4),
    .CNT_WIDTH       (CW)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_sw_start            (i_sw_start),
    .i_sw_step             (i_sw_step),
    .i_btn_next            (i_btn_next),
    .i_ctrl_halt           (i_ctrl_halt),
    .i_car_data            (i_car_data),
    .o_cpu_start           (o_cpu_start),
    .o_step_execution      (o_step_execution),
    .o_next_instr_stimulus (o_next_instr_stimulus),
    .o_run_state           (o_run_state),
    .o_instr_count         (o_instr_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] h_s, h_t, h_b;      // bit j = raw value seen j edges ago
  logic       m_deb_s, m_deb_t, m_deb_b;
  logic       m_dq_s, m_dq_b;
  logic [1:0] m_state;
  logic       m_cpu, m_step, m_pend;
  int         m_cnt;
  logic [6:0] m_prev;

  // Accepted level after this edge, given the raw history and the old level.
  function automatic logic deb_next(input logic [7:0] h, input logic d);
    logic all_differ;
    all_differ = 1'b1;
`ifdef CU_DEBOUNCE_BYPASS_EN
    return h[1];
`else
    for (int j = 2; j < 2 + N; j++) begin
      if (h[j] == d) all_differ = 1'b0;
    end
    return all_differ ? ~d : d;
`endif
  endfunction

  task automatic model_edge();
    logic       rise_s, fall_s, rise_b, ack, win, step_n;
    logic [1:0] ns;
    if (i_rst) begin
      h_s = '0; h_t = '0; h_b = '0;
      m_deb_s = 0; m_deb_t = 0; m_deb_b = 0; m_dq_s = 0; m_dq_b = 0;
      m_state = 2'b00; m_cpu = 0; m_step = 0; m_pend = 0; m_cnt = 0;
      m_prev = 7'h00;
    end else begin
      h_s = {h_s[6:0], i_sw_start};
      h_t = {h_t[6:0], i_sw_step};
      h_b = {h_b[6:0], i_btn_next};
      rise_s = m_deb_s && !m_dq_s;
      fall_s = !m_deb_s && m_dq_s;
      rise_b = m_deb_b && !m_dq_b;
      ack = (i_car_data == 7'h00) && (m_prev != 7'h00);
      ns = m_state;
      if (m_state == 2'b00 && rise_s) ns = 2'b01;
      else if (m_state != 2'b00 && fall_s) ns = 2'b00;
      else if (m_state == 2'b01 && i_ctrl_halt) ns = 2'b10;
      if (m_state == 2'b00 && rise_s) m_cnt = 0;
      else if (m_state == 2'b01 && ack && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
      win = (m_state == 2'b00) || (i_car_data == 7'h00) || (i_car_data == 7'h20);
      step_n = win ? m_deb_t : m_step;
      if (ns != 2'b01 || !m_step) m_pend = 0;
      else if (ack) m_pend = 0;
      else if (rise_b && m_state == 2'b01) m_pend = 1;
      m_cpu = (ns != 2'b00);
      m_state = ns;
      m_step = step_n;
      m_prev = i_car_data;
      m_dq_s = m_deb_s;
      m_dq_b = m_deb_b;
      m_deb_s = deb_next(h_s, m_deb_s);
      m_deb_t = deb_next(h_t, m_deb_t);
      m_deb_b = deb_next(h_b, m_deb_b);
    end
    exp_q.push_back({m_cpu, m_step, m_pend, m_state, m_cnt[CW-1:0]});
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      model_edge();
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cpu_start",   {31'd0, o_cpu_start},           {31'd0, e[8]});
        check("step_exec",   {31'd0, o_step_execution},      {31'd0, e[7]});
        check("next_stim",   {31'd0, o_next_instr_stimulus}, {31'd0, e[6]});
        check("run_state",   {30'd0, o_run_state},           {30'd0, e[5:4]});
        check("instr_count", {28'd0, o_instr_count},         {28'd0, e[3:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic car_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      i_car_data = 7'h01; cycles(1);
      i_car_data = 7'h00; cycles(1);
    end
  endtask

  task automatic random_phase(input int n);
    int hs, ht, hb;
    int sel;
    hs = 0; ht = 0; hb = 0;
    for (int c = 0; c < n; c++) begin
      if (hs == 0) begin i_sw_start = (($urandom_range(0, 3)) != 0); hs = $urandom_range(1, 14); end
      if (ht == 0) begin i_sw_step  = 1'($urandom_range(0, 1)); ht = $urandom_range(1, 10); end
      if (hb == 0) begin i_btn_next = 1'($urandom_range(0, 1)); hb = $urandom_range(1, 9); end
      hs--; ht--; hb--;
      sel = $urandom_range(0, 4);
      case (sel)
        0, 1:    i_car_data = 7'h00;
        2:       i_car_data = 7'h20;
        default: i_car_data = 7'($urandom_range(0, 127));
      endcase
      i_ctrl_halt = ($urandom_range(0, 29) == 0);
      i_rst       = ($urandom_range(0, 399) == 0);
      cycles(1);
    end
    i_rst = 1'b0;
    i_ctrl_halt = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst = 1'b1; i_sw_start = 0; i_sw_step = 0; i_btn_next = 0;
    i_ctrl_halt = 0; i_car_data = 7'h20;
    cycles(3);
    check("rst_cpu_start", {31'd0, o_cpu_start}, 32'd0);
    check("rst_run_state", {30'd0, o_run_state}, 32'd0);
    check("rst_count",     {28'd0, o_instr_count}, 32'd0);
    check("rst_next_stim", {31'd0, o_next_instr_stimulus}, 32'd0);

    // Start rise: cpu_start exactly 7 edges after the raw switch settles.
    i_rst = 1'b0; i_sw_start = 1'b1;
    cycles(6);
    check("start_lat_early", {31'd0, o_cpu_start}, 32'd0);
    cycles(1);
    check("start_lat", {31'd0, o_cpu_start}, 32'd1);
    check("start_state", {30'd0, o_run_state}, 32'd1);
    check("start_count", {28'd0, o_instr_count}, 32'd0);

    // Three-cycle glitch on the run switch is rejected.
    i_sw_start = 1'b0; cycles(3); i_sw_start = 1'b1; cycles(10);
    check("glitch_state", {30'd0, o_run_state}, 32'd1);
    check("glitch_cpu", {31'd0, o_cpu_start}, 32'd1);

    // Step mode and a held step request, acknowledged by CAR -> 0x00.
    i_sw_step = 1'b1; cycles(8);
    check("step_on", {31'd0, o_step_execution}, 32'd1);
    i_btn_next = 1'b1; cycles(8);
    check("req_set", {31'd0, o_next_instr_stimulus}, 32'd1);
    i_btn_next = 1'b0; cycles(8);
    check("req_held", {31'd0, o_next_instr_stimulus}, 32'd1);
    i_car_data = 7'h00; cycles(1);
    check("req_ack", {31'd0, o_next_instr_stimulus}, 32'd0);
    check("ack_count", {28'd0, o_instr_count}, 32'd1);
    i_car_data = 7'h20; cycles(1);
    i_btn_next = 1'b1; cycles(8);
    i_btn_next = 1'b0; cycles(8);
    i_btn_next = 1'b1; cycles(8);   // press while pending: dropped
    i_car_data = 7'h00; cycles(1);
    check("ack2_count", {28'd0, o_instr_count}, 32'd2);
    cycles(1);
    check("no_queue", {31'd0, o_next_instr_stimulus}, 32'd0);
    i_btn_next = 1'b0;

    // Step mode holds mid-instruction.
    i_car_data = 7'h0B; cycles(1);
    i_sw_step = 1'b0; cycles(10);
    check("step_hold", {31'd0, o_step_execution}, 32'd1);
    i_car_data = 7'h20; cycles(1);
    check("step_update", {31'd0, o_step_execution}, 32'd0);

    // HALT is sticky and freezes the counter; start fall returns to IDLE.
    i_ctrl_halt = 1'b1; cycles(1); i_ctrl_halt = 1'b0;
    check("halt_state", {30'd0, o_run_state}, 32'd2);
    check("halt_cpu", {31'd0, o_cpu_start}, 32'd1);
    car_pulses(3);
    check("halt_count", {28'd0, o_instr_count}, 32'd2);
    check("halt_sticky", {30'd0, o_run_state}, 32'd2);
    i_car_data = 7'h20;
    i_sw_start = 1'b0; cycles(7);
    check("idle_state", {30'd0, o_run_state}, 32'd0);
    check("idle_cpu", {31'd0, o_cpu_start}, 32'd0);

    // Restart clears the counter; then the counter saturates.
    i_sw_start = 1'b1; cycles(7);
    check("restart_state", {30'd0, o_run_state}, 32'd1);
    check("restart_count", {28'd0, o_instr_count}, 32'd0);
    car_pulses(17);
    check("sat_count", {28'd0, o_instr_count}, 32'd15);

    // Reset in the middle of activity.
    car_pulses(2);
    i_rst = 1'b1; cycles(1);
    check("mid_rst_cpu", {31'd0, o_cpu_start}, 32'd0);
    check("mid_rst_state", {30'd0, o_run_state}, 32'd0);
    check("mid_rst_count", {28'd0, o_instr_count}, 32'd0);
    i_rst = 1'b0;

    random_phase(3000);

    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cu_run_step_controller.md
Name: cu_run_step_controller

Overview:
- Front-end control stage that sits directly upstream of the control address register.
- Turns raw board switches and the step button into clean control levels:
  - CPU-start level
  - step-mode level
  - held next-instruction stimulus
- Tracks run/halt state from the halt control bit (C23).
- Counts executed instructions by watching the CAR output.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles a synchronized input must hold before it is accepted; legal range 2..65535.
- CNT_WIDTH, 16: width of the instruction counter.

Ports:
- i_clk  input  1  system clock; everything is on the rising edge.
- i_rst  input  1  reset; one clock; reset is synchronous and active-high.
- i_sw_start  input  1  raw asynchronous run switch.
- i_sw_step  input  1  raw asynchronous step-mode switch.
- i_btn_next  input  1  raw asynchronous next-instruction button.
- i_ctrl_halt  input  1  halt control bit C23 from the control buffer.
- i_car_data  input  7  current CAR output.
- o_cpu_start  output  1  CPU-start level to the CAR.
- o_step_execution  output  1  step-mode level to the CAR.
- o_next_instr_stimulus  output  1  held request to fetch the next instruction.
- o_run_state  output  2  00 IDLE, 01 RUN, 10 HALT.
- o_instr_count  output  CNT_WIDTH  number of fetches started since the last start.

Behaviour:
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - synchronizers, debounced values and debounce counters 0
- Synchronizer: each raw input passes through a 2-flop synchronizer.
- Debouncer, one per input (sync value vs accepted value "deb"):
  - sync == deb: counter clears.
  - sync != deb: counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES: deb <= sync and the counter clears.
  - An accepted change appears exactly 2+DEBOUNCE_CYCLES edges after the raw input settles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Edge detection: one registered stage on each deb signal gives single-cycle rise/fall strobes.
- FSM:
  - IDLE -> RUN on a start rise. o_instr_count clears on the same edge.
  - RUN -> HALT when i_ctrl_halt=1.
  - RUN or HALT -> IDLE on a start fall; this has priority over halt.
  - HALT is sticky: it is left only by a start fall.
- o_cpu_start = 1 in RUN and HALT, registered from the state. It rises 1 cycle after the start-rise strobe, which gives the CAR its rising edge to reset to 0x00.
- o_step_execution:
  - Takes the value of the debounced step switch only while one of these holds:
    - FSM is in IDLE
    - i_car_data == 7'h00
    - i_car_data == 7'h20
  - Otherwise it holds, so the mode never changes mid-instruction.
- Step request (pending flag drives o_next_instr_stimulus):
  - Set by a button-rise strobe when FSM=RUN and o_step_execution=1.
  - Cleared on ack: i_car_data == 7'h00 while the registered previous CAR value != 7'h00.
  - Also cleared on leaving RUN, or when o_step_execution=0.
  - Button rises while pending, or outside RUN/step mode, are dropped; there is no queue.
  - Ack and a new rise in the same cycle: the ack wins and the rise is dropped.
- Instruction counter:
  - Increments when FSM=RUN, i_car_data == 7'h00 and the previous CAR value != 7'h00.
  - Saturates at all-ones; it does not wrap.
  - Holds in HALT and IDLE.
- Previous-CAR register: resets to 7'h00 and updates every cycle.
- Reset asserted mid-operation: all state returns to reset values on the next edge, whatever the inputs.

Optional Feature:
- Macro CU_DEBOUNCE_BYPASS_EN.
- Defined:
  - Debounce counters are removed; deb = synchronized value.
  - Acceptance latency is 2 edges.
  - DEBOUNCE_CYCLES is ignored. Intended for simulation and fast benches.
- Not defined: full debounce behaviour as above.

Test Plan:
- DEBOUNCE_CYCLES=4, macro undefined; raise i_sw_start and hold → o_cpu_start=1 exactly 7 edges later, o_run_state=01, o_instr_count=0.
- In RUN, pulse i_sw_start low for 3 cycles then high → no state change, o_cpu_start stays 1.
- RUN with step switch=1 while i_car_data=7'h20; press button ≥4 cycles → o_next_instr_stimulus=1 held. Drive i_car_data=7'h00 → it clears next edge and o_instr_count increments by 1. Press again while pending → ignored.
- RUN with i_ctrl_halt=1 → o_run_state=10, o_cpu_start stays 1, CAR activity does not change the count. Drop the start switch → IDLE, all level outputs 0.
- Toggle the step switch while i_car_data=7'h0B → o_step_execution unchanged until i_car_data reaches 7'h20 or 7'h00.
- With CNT_WIDTH=4, cycle i_car_data 0x01→0x00 17 times in RUN → count stops at 4'hF. Assert i_rst mid-sequence → all outputs 0 on the next edge.
